stream_demux1_to_n: RTL and testbench

Registered 1-to-N stream demultiplexer, the distribution-side counterpart of the 2-to-1 multiplexer. It accepts one valid/ready input stream and routes each packet to the output channel named by a select field. Select is sampled on a packet's first beat and held until its last beat. Every output channel has a one-entry output register, so backpressure is per channel and input-to-output latency is one cycle.

---
 rtl/stream_demux_pkg.sv | 13 +
 rtl/out_slot.sv | 59 +++++
 rtl/stream_demux1_to_n.sv | 137 +++++++++++++
 tb/tb_stream_demux1_to_n.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  // Packet-tracking state: IDLE routes by in_sel, LOCKED by the latched select.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } demux_state_e;

  localparam int DEF_W     = 8;
  localparam int DEF_N_OUT = 4;

endpackage

// File: rtl/out_slot.sv
// One-entry output register with valid/ready handshake. The slot is free when
// empty or when its current beat drains this cycle, so fill and drain can
// happen on the same edge.
module out_slot
  import stream_demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         out_ready,
  output logic         free,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;
  logic         last_q,  last_d;

  assign free      = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

  // Next-state: load a new beat, drain the held one, or keep it stable.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register; reset discards any buffered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/stream_demux1_to_n.sv
// Registered 1-to-N stream demultiplexer. The select is taken from the first
// beat of a packet and held until its last beat. Each channel has its own
// one-entry register, so a stalled channel never blocks traffic to others.
// Optional feature: define DEMUX_ERR_EN to make err a sticky flag for packets
// whose select is out of range; otherwise err is always 0.
module stream_demux1_to_n
  import stream_demux_pkg::*;
#(
  parameter  int N_OUT = DEF_N_OUT,
  parameter  int W     = DEF_W,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic [N_OUT-1:0]   out_last,
  output logic               err
);

  localparam int              N_PAD   = 1 << SEL_W;
  localparam logic [SEL_W:0]  N_OUT_C = (SEL_W+1)'(N_OUT);

  demux_state_e     state_q, state_d;
  logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] target_s;
  logic             in_range_s;
  logic             accept_s;
  logic [N_OUT-1:0] free_s;
  logic [N_PAD-1:0] free_pad_s;
  logic [N_OUT-1:0] load_s;

  assign accept_s = in_valid & in_ready;
  assign err      = err_q;

  // Target channel and input ready; out-of-range targets are always ready so
  // the packet is swallowed.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      target_s = lock_sel_q;
    end else begin
      target_s = in_sel;
    end
    in_range_s = ({1'b0, target_s} < N_OUT_C);
    free_pad_s = '0;
    free_pad_s[N_OUT-1:0] = free_s;
    if (in_range_s) begin
      in_ready = free_pad_s[target_s];
    end else begin
      in_ready = 1'b1;
    end
  end

  // One-hot load strobe to the target channel on an accepted in-range beat.
  always_comb begin
    load_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load_s[k] = accept_s & in_range_s & (target_s == SEL_W'(k));
    end
  end

  // Packet FSM, select lock and sticky error flag.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !in_last) begin
          state_d    = ST_LOCKED;
          lock_sel_d = in_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef DEMUX_ERR_EN
    if ((state_q == ST_IDLE) && accept_s && !in_range_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
`else
    err_d = 1'b0;
`endif
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_OUT; g++) begin : g_slot
      out_slot #(.W(W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s[g]),
        .load_data (in_data),
        .load_last (in_last),
        .out_ready (out_ready[g]),
        .free      (free_s[g]),
        .out_valid (out_valid[g]),
        .out_data  (out_data[g*W +: W]),
        .out_last  (out_last[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux1_to_n.sv
// Directed bench for stream_demux1_to_n: a 4-channel instance for routing,
// backpressure, throughput and reset, plus a 3-channel instance for the
// out-of-range select path (err expectation follows DEMUX_ERR_EN).
module tb_stream_demux1_to_n;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        err;

  logic        in_valid3, in_ready3, in_last3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3, out_ready3, out_last3;
  logic [23:0] out_data3;
  logic        err3;

  int n_vec = 0;
  int n_err = 0;

`ifdef DEMUX_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  stream_demux1_to_n #(.N_OUT(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err)
  );

  stream_demux1_to_n #(.N_OUT(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_sel(in_sel3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .err(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    out_ready  = 4'b0000;
    in_valid3  = 1'b0;
    in_sel3    = 2'd0;
    in_data3   = 8'h00;
    in_last3   = 1'b0;
    out_ready3 = 3'b111;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err3", 32'(err3), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single-beat packet to channel 2
    drive(1'b1, 2'd2, 8'hA5, 1'b1);
    #1 chk("t1_ready", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'h4);
    chk("t1_data", 32'(out_data[23:16]), 32'hA5);
    chk("t1_last", 32'(out_last), 32'h4);
    out_ready = 4'b0100;
    tick();
    chk("t1_drain", 32'(out_valid), 32'h0);

    // Three-beat packet locked to channel 1 despite in_sel=3 later
    out_ready = 4'b1111;
    drive(1'b1, 2'd1, 8'h11, 1'b0);
    tick();
    chk("t2_b0_valid", 32'(out_valid), 32'h2);
    chk("t2_b0_data", 32'(out_data[15:8]), 32'h11);
    chk("t2_b0_last", 32'(out_last[1]), 32'h0);
    drive(1'b1, 2'd3, 8'h22, 1'b0);
    tick();
    chk("t2_b1_valid", 32'(out_valid), 32'h2);
    chk("t2_b1_data", 32'(out_data[15:8]), 32'h22);
    chk("t2_b1_last", 32'(out_last[1]), 32'h0);
    drive(1'b1, 2'd3, 8'h33, 1'b1);
    tick();
    chk("t2_b2_valid", 32'(out_valid), 32'h2);
    chk("t2_b2_data", 32'(out_data[15:8]), 32'h33);
    chk("t2_b2_last", 32'(out_last[1]), 32'h1);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("t2_idle", 32'(out_valid), 32'h0);

    // Channel 0 stalled full; channel 2 unaffected
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 8'h44, 1'b1);
    tick();
    chk("t3_fill0", 32'(out_valid), 32'h1);
    drive(1'b1, 2'd0, 8'h55, 1'b1);
    #1 chk("t3_ready0", 32'(in_ready), 32'h0);
    tick();
    chk("t3_hold0", 32'(out_data[7:0]), 32'h44);
    drive(1'b1, 2'd2, 8'h66, 1'b1);
    #1 chk("t3_ready2", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t3_valid", 32'(out_valid), 32'h5);
    chk("t3_data2", 32'(out_data[23:16]), 32'h66);
    chk("t3_data0", 32'(out_data[7:0]), 32'h44);
    out_ready = 4'b1111;
    tick();
    chk("t3_drain", 32'(out_valid), 32'h0);

    // Eight back-to-back beats to channel 3
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? 2'd3 : 2'd0, 8'(8'h80 + i), (i == 7));
      #1 chk("t4_ready", 32'(in_ready), 32'h1);
      tick();
      chk("t4_valid", 32'(out_valid), 32'h8);
      chk("t4_data", 32'(out_data[31:24]), 32'(8'h80 + i));
      chk("t4_last", 32'(out_last[3]), 32'((i == 7) ? 1 : 0));
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("t4_idle", 32'(out_valid), 32'h0);

    // Reset mid-packet after beat 2 of 4, then new packet to channel 0
    drive(1'b1, 2'd1, 8'hC0, 1'b0);
    tick();
    drive(1'b1, 2'd1, 8'hC1, 1'b0);
    tick();
    chk("t5_pre", 32'(out_valid), 32'h2);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1 chk("t5_async", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 2'd0, 8'hD0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t5_valid", 32'(out_valid), 32'h1);
    chk("t5_data", 32'(out_data[7:0]), 32'hD0);

    // Out-of-range select on the 3-channel instance
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hEE; in_last3 = 1'b0;
    #1 chk("t6_ready_b0", 32'(in_ready3), 32'h1);
    tick();
    chk("t6_valid_b0", 32'(out_valid3), 32'h0);
    chk("t6_err_b0", 32'(err3), 32'(EXP_ERR));
    in_sel3 = 2'd0; in_data3 = 8'hEF; in_last3 = 1'b1;
    #1 chk("t6_ready_b1", 32'(in_ready3), 32'h1);
    tick();
    chk("t6_valid_b1", 32'(out_valid3), 32'h0);
    in_valid3 = 1'b0; in_last3 = 1'b0;
    tick();
    chk("t6_err_hold", 32'(err3), 32'(EXP_ERR));
    in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 8'h12; in_last3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    chk("t6_after_valid", 32'(out_valid3), 32'h1);
    chk("t6_after_data", 32'(out_data3[7:0]), 32'h12);
    chk("t6_err_main", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
